// File: rtl/controlador_mascota.sv
// controlador_mascota: scheduler for the virtual-pet need modes.
// Routes the action button to the selected mode, waits on its feedback pulse and tracks pet health.
module controlador_mascota #(
  parameter  int N_MODOS    = 4,
  parameter  int TICKS_1S   = 50_000_000,
  parameter  int T_INACTIVO = 10,
  parameter  int T_MUERTE   = 5,
  localparam int SEL_W      = $clog2(N_MODOS)
) (
  input  logic                 clk,
  input  logic                 B_reset,
  input  logic                 B_siguiente,
  input  logic                 B_accion,
  input  logic [2*N_MODOS-1:0] niveles,
  input  logic [N_MODOS-1:0]   senal_5seg,
  output logic                 activo,
  output logic [N_MODOS-1:0]   entrada_modo,
  output logic [SEL_W-1:0]     seleccion,
  output logic [1:0]           estado_fsm,
  output logic [1:0]           estado_mascota
);

  localparam int PRE_W = $clog2(TICKS_1S + 1);
  localparam int INA_W = $clog2(T_INACTIVO + 1);
  localparam int MUE_W = $clog2(T_MUERTE + 1);

  typedef enum logic [1:0] {REPOSO, SELECCION, ACCION, MUERTO} estado_t;
  typedef enum logic [1:0] {MASCOTA_FELIZ, MASCOTA_NECESIDAD, MASCOTA_CRITICO, MASCOTA_MUERTO} mascota_t;

  estado_t          estado, estado_n;
  logic [2:0]       sinc_sig, sinc_acc;
  logic             flanco_sig, flanco_acc;
  logic [PRE_W-1:0] cnt_pre;
  logic             tick;
  logic [INA_W-1:0] cnt_inact, inact_n;
  logic [MUE_W-1:0] cnt_muerte;
  logic             muerte;
  logic             segundo_ciclo, segundo_n;
  logic             visto, visto_n;
  logic [SEL_W-1:0] sel_n;
  logic [N_MODOS-1:0] entrada_n;
  logic             algun_cero, algun_uno;

  // Two-FF synchronizer, then a registered rising-edge pulse per button.
  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset) begin
      sinc_sig   <= '0;
      sinc_acc   <= '0;
      flanco_sig <= 1'b0;
      flanco_acc <= 1'b0;
    end else begin
      sinc_sig   <= {sinc_sig[1:0], B_siguiente};
      sinc_acc   <= {sinc_acc[1:0], B_accion};
      flanco_sig <= sinc_sig[1] & ~sinc_sig[2];
      flanco_acc <= sinc_acc[1] & ~sinc_acc[2];
    end
  end

  assign tick = (cnt_pre == PRE_W'(TICKS_1S - 1));

  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset)   cnt_pre <= '0;
    else if (tick) cnt_pre <= '0;
    else           cnt_pre <= cnt_pre + PRE_W'(1);
  end

  always_comb begin
    algun_cero = 1'b0;
    algun_uno  = 1'b0;
    for (int i = 0; i < N_MODOS; i++) begin
      if (niveles[2*i +: 2] == 2'd0) algun_cero = 1'b1;
      if (niveles[2*i +: 2] == 2'd1) algun_uno  = 1'b1;
    end
  end

  // Death monitor saturates at T_MUERTE so the override stays asserted.
  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset)                                     cnt_muerte <= '0;
    else if (!algun_cero)                            cnt_muerte <= '0;
    else if (tick && cnt_muerte != MUE_W'(T_MUERTE)) cnt_muerte <= cnt_muerte + MUE_W'(1);
  end

  assign muerte = (cnt_muerte == MUE_W'(T_MUERTE));

  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset) begin
      estado        <= REPOSO;
      seleccion     <= '0;
      entrada_modo  <= '0;
      cnt_inact     <= '0;
      segundo_ciclo <= 1'b0;
      visto         <= 1'b0;
    end else begin
      estado        <= estado_n;
      seleccion     <= sel_n;
      entrada_modo  <= entrada_n;
      cnt_inact     <= inact_n;
      segundo_ciclo <= segundo_n;
      visto         <= visto_n;
    end
  end

  always_comb begin
    estado_n  = estado;
    sel_n     = seleccion;
    entrada_n = entrada_modo;
    inact_n   = cnt_inact;
    segundo_n = segundo_ciclo;
    visto_n   = visto;
    case (estado)
      REPOSO: begin
        if (flanco_sig) begin
          estado_n = SELECCION;
          sel_n    = '0;
        end
      end
      SELECCION: begin
        if (flanco_acc) begin
          entrada_n[seleccion] = ~entrada_modo[seleccion];
          estado_n             = ACCION;
        end else if (flanco_sig) begin
          sel_n   = (seleccion == SEL_W'(N_MODOS - 1)) ? '0 : seleccion + SEL_W'(1);
          inact_n = '0;
        end else if (tick) begin
          if (cnt_inact == INA_W'(T_INACTIVO - 1)) estado_n = REPOSO;
          else                                     inact_n  = cnt_inact + INA_W'(1);
        end
      end
      ACCION: begin
        // Once the mode has answered, wait for its pulse to end; otherwise the window decides.
        if (visto) begin
          if (!senal_5seg[seleccion]) estado_n = SELECCION;
        end else if (senal_5seg[seleccion]) begin
          visto_n = 1'b1;
        end else if (segundo_ciclo) begin
          estado_n = SELECCION;
        end else begin
          segundo_n = 1'b1;
        end
      end
      default: ;
    endcase
    if (muerte && estado != MUERTO) begin
      estado_n  = MUERTO;
      sel_n     = seleccion;
      entrada_n = entrada_modo;
    end
    if (estado_n != estado) begin
      inact_n   = '0;
      segundo_n = 1'b0;
      visto_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset)               estado_mascota <= MASCOTA_FELIZ;
    else if (estado == MUERTO) estado_mascota <= MASCOTA_MUERTO;
    else if (algun_cero)       estado_mascota <= MASCOTA_CRITICO;
    else if (algun_uno)        estado_mascota <= MASCOTA_NECESIDAD;
    else                       estado_mascota <= MASCOTA_FELIZ;
  end

  assign estado_fsm = estado;
  assign activo     = (estado != MUERTO);

endmodule

// File: tb/tb_controlador_mascota.sv
// tb_controlador_mascota: table, random and sequence checks for controlador_mascota.
// Uses a 4-cycle second so inactivity and death fit in a short run.
module tb_controlador_mascota;

  logic       clk = 1'b0;
  logic       B_reset;
  logic       B_siguiente;
  logic       B_accion;
  logic [7:0] niveles;
  logic [3:0] senal_5seg;
  logic       activo;
  logic [3:0] entrada_modo;
  logic [1:0] seleccion;
  logic [1:0] estado_fsm;
  logic [1:0] estado_mascota;

  int vectores = 0;
  int fallos   = 0;

  typedef struct {
    logic [7:0] niveles;
    logic [1:0] mascota;
  } vector_t;

  vector_t tabla[12];

  controlador_mascota #(
    .N_MODOS(4), .TICKS_1S(4), .T_INACTIVO(3), .T_MUERTE(2)
  ) dut (
    .clk(clk),
    .B_reset(B_reset),
    .B_siguiente(B_siguiente),
    .B_accion(B_accion),
    .niveles(niveles),
    .senal_5seg(senal_5seg),
    .activo(activo),
    .entrada_modo(entrada_modo),
    .seleccion(seleccion),
    .estado_fsm(estado_fsm),
    .estado_mascota(estado_mascota)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string nombre, input logic [7:0] actual, input logic [7:0] esperado);
    vectores++;
    if (actual !== esperado) begin
      fallos++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nombre, actual, esperado, $time);
    end
  endtask

  // Called on a falling edge; the new levels are registered by the next rising edge.
  task automatic applyStimulus(input logic [7:0] n);
    niveles = n;
    @(negedge clk);
  endtask

  // Holds the buttons for two cycles and returns one cycle after the resulting update.
  task automatic press(input logic sig, input logic acc);
    @(negedge clk);
    B_siguiente = sig;
    B_accion    = acc;
    repeat (2) @(negedge clk);
    B_siguiente = 1'b0;
    B_accion    = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Health reference: the lowest level decides the mood.
  function automatic logic [1:0] modeloMascota(input logic [7:0] n);
    int minimo = 3;
    for (int i = 0; i < 4; i++) begin
      int lv = int'(n[2*i +: 2]);
      if (lv < minimo) minimo = lv;
    end
    if (minimo == 0)      return 2'd2;
    else if (minimo == 1) return 2'd1;
    else                  return 2'd0;
  endfunction

  task automatic checkReset(input string etiqueta);
    checkOutput({etiqueta, "_fsm"},     8'(estado_fsm),     8'd0);
    checkOutput({etiqueta, "_sel"},     8'(seleccion),      8'd0);
    checkOutput({etiqueta, "_entrada"}, 8'(entrada_modo),   8'd0);
    checkOutput({etiqueta, "_activo"},  8'(activo),         8'd1);
    checkOutput({etiqueta, "_mascota"}, 8'(estado_mascota), 8'd0);
  endtask

  initial begin
    logic [3:0] previa;
    logic       encontrado;
    logic       prev_cero;
    logic [7:0] aleatorio;
    logic [1:0] esperados[5];

    tabla[0]  = '{8'hFF, 2'd0};
    tabla[1]  = '{8'hFD, 2'd1};
    tabla[2]  = '{8'hFE, 2'd0};
    tabla[3]  = '{8'hFC, 2'd2};
    tabla[4]  = '{8'hBF, 2'd0};
    tabla[5]  = '{8'h7F, 2'd1};
    tabla[6]  = '{8'h3F, 2'd2};
    tabla[7]  = '{8'h55, 2'd1};
    tabla[8]  = '{8'h00, 2'd2};
    tabla[9]  = '{8'hAA, 2'd0};
    tabla[10] = '{8'hF3, 2'd2};
    tabla[11] = '{8'hFF, 2'd0};
    esperados = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    B_reset     = 1'b1;
    B_siguiente = 1'b0;
    B_accion    = 1'b0;
    niveles     = 8'hFF;
    senal_5seg  = 4'b0000;
    repeat (2) @(negedge clk);
    B_reset = 1'b0;
    @(negedge clk);
    checkReset("reset_init");

    // Selection wrap from REPOSO.
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0);
      checkOutput("wrap_fsm", 8'(estado_fsm), 8'd1);
      checkOutput("wrap_sel", 8'(seleccion), 8'(esperados[i]));
    end

    // Action on mode 2 with a 7-cycle busy pulse; a siguiente press during ACCION is dropped.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checkOutput("sel_two", 8'(seleccion), 8'd2);
    previa = entrada_modo;
    B_accion = 1'b1;
    encontrado = 1'b0;
    for (int i = 0; i < 10 && !encontrado; i++) begin
      @(negedge clk);
      if (i == 1) B_accion = 1'b0;
      if (entrada_modo !== previa) encontrado = 1'b1;
    end
    B_accion = 1'b0;
    checkOutput("toggle_seen", 8'(encontrado), 8'd1);
    checkOutput("toggle_value", 8'(entrada_modo), 8'b0100);
    checkOutput("accion_entry", 8'(estado_fsm), 8'd2);
    B_siguiente = 1'b1;
    @(negedge clk);
    senal_5seg[2] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) B_siguiente = 1'b0;
      checkOutput("busy_wait", 8'(estado_fsm), 8'd2);
    end
    senal_5seg[2] = 1'b0;
    @(negedge clk);
    checkOutput("busy_exit", 8'(estado_fsm), 8'd1);
    checkOutput("busy_sel_kept", 8'(seleccion), 8'd2);
    checkOutput("busy_entrada", 8'(entrada_modo), 8'b0100);

    // Refused action: no feedback, two-cycle window then back to SELECCION.
    press(1'b0, 1'b1);
    checkOutput("refused_in", 8'(estado_fsm), 8'd2);
    checkOutput("refused_toggle", 8'(entrada_modo), 8'b0000);
    @(negedge clk);
    checkOutput("refused_out", 8'(estado_fsm), 8'd1);

    // Inactivity: 8 cycles hold at most 2 ticks, 13 cycles always contain 3.
    repeat (8) @(negedge clk);
    checkOutput("inact_early", 8'(estado_fsm), 8'd1);
    repeat (5) @(negedge clk);
    checkOutput("inact_reposo", 8'(estado_fsm), 8'd0);
    checkOutput("inact_sel_kept", 8'(seleccion), 8'd2);

    // Simultaneous edges: action wins on the current index.
    press(1'b1, 1'b0);
    checkOutput("reenter_sel", 8'(seleccion), 8'd0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    checkOutput("both_fsm", 8'(estado_fsm), 8'd2);
    checkOutput("both_sel", 8'(seleccion), 8'd1);
    checkOutput("both_entrada", 8'(entrada_modo), 8'b0010);
    @(negedge clk);
    checkOutput("both_exit", 8'(estado_fsm), 8'd1);
    repeat (16) @(negedge clk);
    checkOutput("idle_reposo", 8'(estado_fsm), 8'd0);

    // Health table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tabla[i].niveles);
      checkOutput("tabla_mascota", 8'(estado_mascota), 8'(tabla[i].mascota));
    end

    // Random levels; a zero never lasts two cycles, so death cannot trigger.
    prev_cero = 1'b0;
    for (int i = 0; i < 150; i++) begin
      aleatorio = 8'($urandom);
      if (prev_cero) begin
        for (int j = 0; j < 4; j++)
          if (aleatorio[2*j +: 2] == 2'd0) aleatorio[2*j +: 2] = 2'(1 + $urandom_range(0, 2));
      end
      prev_cero = (modeloMascota(aleatorio) == 2'd2);
      applyStimulus(aleatorio);
      checkOutput("rand_mascota", 8'(estado_mascota), 8'(modeloMascota(aleatorio)));
    end
    applyStimulus(8'hFF);
    checkOutput("rand_alive", 8'(estado_fsm), 8'd0);

    // Level-0 pulse covering exactly one tick: no death.
    niveles = 8'hFC;
    @(negedge clk);
    checkOutput("pulse_critico", 8'(estado_mascota), 8'd2);
    repeat (3) @(negedge clk);
    niveles = 8'hFF;
    repeat (12) @(negedge clk);
    checkOutput("pulse_alive", 8'(estado_fsm), 8'd0);
    checkOutput("pulse_activo", 8'(activo), 8'd1);

    // Sustained level 0: death after the second tick.
    niveles = 8'hFC;
    repeat (4) @(negedge clk);
    checkOutput("death_not_yet", 8'(estado_fsm), 8'd0);
    repeat (7) @(negedge clk);
    checkOutput("death_fsm", 8'(estado_fsm), 8'd3);
    checkOutput("death_mascota", 8'(estado_mascota), 8'd3);
    checkOutput("death_activo", 8'(activo), 8'd0);
    niveles = 8'hFF;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checkOutput("dead_fsm", 8'(estado_fsm), 8'd3);
    checkOutput("dead_sel", 8'(seleccion), 8'd1);
    checkOutput("dead_entrada", 8'(entrada_modo), 8'b0010);
    checkOutput("dead_mascota", 8'(estado_mascota), 8'd3);
    checkOutput("dead_activo", 8'(activo), 8'd0);

    // Reset out of death, then asynchronous reset in the middle of ACCION.
    B_reset = 1'b1;
    @(negedge clk);
    B_reset = 1'b0;
    @(negedge clk);
    checkReset("reset_dead");
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    senal_5seg[0] = 1'b1;
    @(negedge clk);
    checkOutput("hold_accion", 8'(estado_fsm), 8'd2);
    checkOutput("hold_entrada", 8'(entrada_modo), 8'b0001);
    B_reset = 1'b1;
    #1;
    checkReset("reset_async");
    @(negedge clk);
    B_reset    = 1'b0;
    senal_5seg = 4'b0000;
    @(negedge clk);
    checkReset("reset_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

endmodule
